// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and RAM-side bundle for the shared memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8
);
  logic                  vid_req;
  logic [ADDR_WIDTH-1:0] vid_addr;
  logic                  vid_gnt;
  logic                  vid_rvalid;

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0] cpu_wdata;
  logic                  cpu_gnt;
  logic                  cpu_rvalid;

  logic                  dma_req;
  logic                  dma_we;
  logic [ADDR_WIDTH-1:0] dma_addr;
  logic [DATA_WIDTH-1:0] dma_wdata;
  logic                  dma_gnt;
  logic                  dma_rvalid;

  logic [DATA_WIDTH-1:0] rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  vid_req, vid_addr,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output vid_gnt, vid_rvalid,
    output cpu_gnt, cpu_rvalid,
    output dma_gnt, dma_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  // Requesters plus RAM macro
  modport master (
    output vid_req, vid_addr,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  vid_gnt, vid_rvalid,
    input  cpu_gnt, cpu_rvalid,
    input  dma_gnt, dma_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - video-priority arbiter with CPU/DMA round-robin and starvation override
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic             rr_dma;
  logic [CNT_W-1:0] cpu_cnt;
  logic [CNT_W-1:0] dma_cnt;

  logic cpu_forced;
  logic dma_forced;
  logic vid_pick;
  logic cpu_pick;
  logic dma_pick;
  logic vid_gnt;
  logic cpu_gnt;
  logic dma_gnt;

  function automatic logic [CNT_W-1:0] next_cnt(
    input logic [CNT_W-1:0] cnt,
    input logic             req,
    input logic             gnt
  );
    if (!req || gnt) begin
      return '0;
    end else if (cnt == LIMIT) begin
      return cnt;
    end else begin
      return cnt + CNT_W'(1);
    end
  endfunction

  assign cpu_forced = bus.cpu_req && (cpu_cnt == LIMIT);
  assign dma_forced = bus.dma_req && (dma_cnt == LIMIT);

  always_comb begin
    vid_pick = 1'b0;
    cpu_pick = 1'b0;
    dma_pick = 1'b0;
    if (cpu_forced && dma_forced) begin
      cpu_pick = !rr_dma;
      dma_pick = rr_dma;
    end else if (cpu_forced) begin
      cpu_pick = 1'b1;
    end else if (dma_forced) begin
      dma_pick = 1'b1;
    end else if (bus.vid_req) begin
      vid_pick = 1'b1;
    end else if (bus.cpu_req && bus.dma_req) begin
      cpu_pick = !rr_dma;
      dma_pick = rr_dma;
    end else if (bus.cpu_req) begin
      cpu_pick = 1'b1;
    end else if (bus.dma_req) begin
      dma_pick = 1'b1;
    end
  end

  // Grants are suppressed combinationally so no access leaks out during reset.
  assign vid_gnt = vid_pick && rst_n;
  assign cpu_gnt = cpu_pick && rst_n;
  assign dma_gnt = dma_pick && rst_n;

  assign bus.vid_gnt = vid_gnt;
  assign bus.cpu_gnt = cpu_gnt;
  assign bus.dma_gnt = dma_gnt;
  assign bus.mem_en  = vid_gnt || cpu_gnt || dma_gnt;
  assign bus.rdata   = bus.mem_rdata;

  always_comb begin
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (vid_gnt) begin
      bus.mem_addr = bus.vid_addr;
    end else if (cpu_gnt) begin
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (dma_gnt) begin
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_dma         <= 1'b0;
      cpu_cnt        <= '0;
      dma_cnt        <= '0;
      bus.vid_rvalid <= 1'b0;
      bus.cpu_rvalid <= 1'b0;
      bus.dma_rvalid <= 1'b0;
    end else begin
      if (cpu_gnt) begin
        rr_dma <= 1'b1;
      end else if (dma_gnt) begin
        rr_dma <= 1'b0;
      end
      cpu_cnt        <= next_cnt(cpu_cnt, bus.cpu_req, cpu_gnt);
      dma_cnt        <= next_cnt(dma_cnt, bus.dma_req, dma_gnt);
      bus.vid_rvalid <= vid_gnt;
      bus.cpu_rvalid <= cpu_gnt && !bus.cpu_we;
      bus.dma_rvalid <= dma_gnt && !bus.dma_we;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural sync-read RAM
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int SL = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] mem_rd_q;

  assign bus.mem_rdata = mem_rd_q;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      mem_rd_q <= mem[bus.mem_addr];
    end
  end

  typedef struct {
    logic [2:0]    id;
    logic [DW-1:0] data;
  } sb_t;
  sb_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Read expectations come from the address the requester presented, not from mem_addr.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (bus.vid_rvalid || bus.cpu_rvalid || bus.dma_rvalid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("rv_id", {bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, e.id);
          chk("rv_data", bus.rdata, e.data);
        end
      end
      chk("gnt_onehot", ($countones({bus.vid_gnt, bus.cpu_gnt, bus.dma_gnt}) > 1), 0);
      chk("mem_en_or", bus.mem_en, bus.vid_gnt | bus.cpu_gnt | bus.dma_gnt);
      if (bus.vid_gnt) begin
        chk("vid_maddr", bus.mem_addr, bus.vid_addr);
        chk("vid_mwe", bus.mem_we, 0);
        sb.push_back('{3'b100, ref_mem[bus.vid_addr]});
      end
      if (bus.cpu_gnt) begin
        chk("cpu_maddr", bus.mem_addr, bus.cpu_addr);
        chk("cpu_mwe", bus.mem_we, bus.cpu_we);
        if (bus.cpu_we) begin
          chk("cpu_mwdata", bus.mem_wdata, bus.cpu_wdata);
          ref_mem[bus.cpu_addr] = bus.cpu_wdata;
        end else begin
          sb.push_back('{3'b010, ref_mem[bus.cpu_addr]});
        end
      end
      if (bus.dma_gnt) begin
        chk("dma_maddr", bus.mem_addr, bus.dma_addr);
        chk("dma_mwe", bus.mem_we, bus.dma_we);
        if (bus.dma_we) begin
          chk("dma_mwdata", bus.mem_wdata, bus.dma_wdata);
          ref_mem[bus.dma_addr] = bus.dma_wdata;
        end else begin
          sb.push_back('{3'b001, ref_mem[bus.dma_addr]});
        end
      end
    end
  end

  task automatic clear_reqs();
    bus.vid_req   = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.dma_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.dma_we    = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < (1 << AW); a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a]     = av[7:0] ^ av[15:8] ^ 8'h3C;
      ref_mem[a] = av[7:0] ^ av[15:8] ^ 8'h3C;
    end
    mem[16'h1234]     = 8'h5A;
    ref_mem[16'h1234] = 8'h5A;
    mem_rd_q = '0;

    rst_n         = 1'b0;
    clear_reqs();
    bus.vid_addr  = '0;
    bus.cpu_addr  = '0;
    bus.dma_addr  = '0;
    bus.cpu_wdata = '0;
    bus.dma_wdata = '0;

    // Requests during reset must not be granted
    bus.cpu_req = 1'b1;
    bus.vid_req = 1'b1;
    @(negedge clk);
    chk("rst_gnt", {bus.vid_gnt, bus.cpu_gnt, bus.dma_gnt, bus.mem_en}, 0);
    chk("rst_rvalid", {bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle", {bus.mem_en, bus.vid_gnt, bus.cpu_gnt, bus.dma_gnt,
                   bus.vid_rvalid, bus.cpu_rvalid, bus.dma_rvalid}, 0);
    end
    step();

    // Single CPU read
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h1234;
    @(negedge clk);
    chk("cpu_rd_gnt", bus.cpu_gnt, 1);
    chk("cpu_rd_addr", bus.mem_addr, 16'h1234);
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("cpu_rd_rvalid", bus.cpu_rvalid, 1);
    chk("cpu_rd_data", bus.rdata, 8'h5A);
    chk("cpu_rd_nognt", bus.cpu_gnt, 0);

    // CPU/DMA alternation from reset
    do_reset();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0100;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0200;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rr_cpu", bus.cpu_gnt, (i % 2) == 0);
      chk("rr_dma", bus.dma_gnt, (i % 2) == 1);
      chk("rr_vid", bus.vid_gnt, 0);
      step();
    end

    // Video vs CPU: forced CPU grant every STARVE_LIMIT+1 cycles
    do_reset();
    bus.vid_req  = 1'b1;
    bus.vid_addr = 16'h3000;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0040;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("starve_cpu", bus.cpu_gnt, (i % (SL + 1)) == SL);
      chk("starve_vid", bus.vid_gnt, (i % (SL + 1)) != SL);
      step();
    end

    // Video vs CPU and DMA: both saturate together, pointer resolves, loser follows next cycle
    do_reset();
    bus.vid_req  = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.dma_req  = 1'b1;
    bus.dma_addr = 16'h0050;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("dual_cpu", bus.cpu_gnt, (i % (SL + 1)) == SL);
      chk("dual_dma", bus.dma_gnt, (i > 0) && ((i % (SL + 1)) == 0));
      chk("dual_vid", bus.vid_gnt, (i % (SL + 1)) != SL && !((i > 0) && ((i % (SL + 1)) == 0)));
      step();
    end
    clear_reqs();
    step();

    // DMA write then CPU read-back
    bus.dma_req   = 1'b1;
    bus.dma_we    = 1'b1;
    bus.dma_addr  = 16'h0010;
    bus.dma_wdata = 8'hA5;
    @(negedge clk);
    chk("dma_wr_gnt", bus.dma_gnt, 1);
    chk("dma_wr_en", {bus.mem_en, bus.mem_we}, 2'b11);
    chk("dma_wr_data", bus.mem_wdata, 8'hA5);
    step();
    bus.dma_req  = 1'b0;
    bus.dma_we   = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 16'h0010;
    @(negedge clk);
    chk("dma_wr_norv", bus.dma_rvalid, 0);
    chk("rb_gnt", bus.cpu_gnt, 1);
    step();
    bus.cpu_req = 1'b0;
    @(negedge clk);
    chk("rb_rvalid", bus.cpu_rvalid, 1);
    chk("rb_data", bus.rdata, 8'hA5);
    step();

    // Reset between a DMA read grant and its rvalid
    bus.dma_req  = 1'b1;
    bus.dma_we   = 1'b0;
    bus.dma_addr = 16'h0020;
    @(negedge clk);
    chk("rstmid_gnt", bus.dma_gnt, 1);
    #1;
    rst_n       = 1'b0;
    bus.dma_req = 1'b0;
    @(negedge clk);
    chk("rstmid_norv", bus.dma_rvalid, 0);
    step();
    rst_n       = 1'b1;
    bus.cpu_req = 1'b1;
    bus.dma_req = 1'b1;
    @(negedge clk);
    chk("post_rst_norv", bus.dma_rvalid, 0);
    chk("post_rst_cpu", bus.cpu_gnt, 1);
    chk("post_rst_dma0", bus.dma_gnt, 0);
    step();
    @(negedge clk);
    chk("post_rst_dma1", bus.dma_gnt, 1);
    step();
    clear_reqs();
    repeat (3) step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
